// File: rtl/fp32_mul_pkg.sv
// Shared types and constants for the FP32 multiplier issue/collect sequencer.
package fp32_mul_pkg;

  localparam int unsigned FP32_W = 32;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned FLG_NAN = 0;
  localparam int unsigned FLG_INF = 1;
  localparam int unsigned FLG_OVF = 2;
  localparam int unsigned FLG_UNF = 3;
  localparam int unsigned FLG_TMO = 4;

  localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [FP32_W-1:0] a;
    logic [FP32_W-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/fp32_mul_sequencer_if.sv
// Operand-in / result-out stream bundle; the sequencer is the slave side.
interface fp32_mul_sequencer_if
  import fp32_mul_pkg::*;
();
  logic              in_valid;
  logic              in_ready;
  logic [FP32_W-1:0] in_a;
  logic [FP32_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [FP32_W-1:0] out_product;
  logic [FLAG_W-1:0] out_flags;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product, out_flags
  );
endinterface

// File: rtl/fp32_operand_fifo.sv
// Synchronous FIFO of operand pairs; push/pop are ignored when full/empty.
module fp32_operand_fifo
  import fp32_mul_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  operand_pair_t push_data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output operand_pair_t head_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  operand_pair_t mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fp32_mul_sequencer.sv
// Issues buffered operand pairs to the FP32 multiplier core one at a time and
// holds each product with sticky exception flags until the consumer takes it.
module fp32_mul_sequencer
  import fp32_mul_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  fp32_mul_sequencer_if.slave s_if,
  output logic                mul_start_o,
  output logic [FP32_W-1:0]   mul_a_o,
  output logic [FP32_W-1:0]   mul_b_o,
  input  logic                mul_done_i,
  input  logic [FP32_W-1:0]   mul_product_i,
  input  logic                mul_nan_i,
  input  logic                mul_inf_i,
  input  logic                mul_ovf_i,
  input  logic                mul_unf_i,
  output logic                busy_o
);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned ACC_W = FLAG_W - 1;

  seq_state_t        state_q, state_d;
  logic              start_q, start_d;
  logic [FP32_W-1:0] a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [FP32_W-1:0] prod_q, prod_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              busy_q, busy_d;

  logic              fifo_full, fifo_empty, fifo_pop_c;
  operand_pair_t     fifo_head, push_pair;
  logic [ACC_W-1:0]  core_flags;

  assign push_pair  = '{a: s_if.in_a, b: s_if.in_b};
  assign core_flags = {mul_unf_i, mul_ovf_i, mul_inf_i, mul_nan_i};

  fp32_operand_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (s_if.in_valid),
    .push_data_i (push_pair),
    .pop_i       (fifo_pop_c),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  // Operands are loaded on the edge into ISSUE so start is high exactly during ISSUE.
  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    prod_d     = prod_q;
    flags_d    = flags_q;
    fifo_pop_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop_c = 1'b1;
          a_d        = fifo_head.a;
          b_d        = fifo_head.b;
          start_d    = 1'b1;
          acc_d      = '0;
          cnt_d      = '0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        acc_d = acc_q | core_flags;
        cnt_d = cnt_q + TMO_W'(1);
        if (mul_done_i) begin
          prod_d  = mul_product_i;
          flags_d = {1'b0, acc_q | core_flags};
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else if (cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          prod_d  = FP32_QNAN;
          flags_d = {1'b1, acc_q};
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (s_if.out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      prod_q  <= '0;
      flags_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      prod_q  <= prod_d;
      flags_q <= flags_d;
      busy_q  <= busy_d;
    end
  end

  assign s_if.in_ready    = !fifo_full;
  assign s_if.out_valid   = valid_q;
  assign s_if.out_product = prod_q;
  assign s_if.out_flags   = flags_q;
  assign mul_start_o      = start_q;
  assign mul_a_o          = a_q;
  assign mul_b_o          = b_q;
  assign busy_o           = busy_q;

endmodule

// File: doc/fp32_mul_sequencer.md
Name: fp32_mul_sequencer

Overview:
Upstream issue/downstream collect stage wrapped around the 32-bit FP multiplier core. Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO. Issues each pair to the core with a one-cycle start pulse, waits for its done pulse, and captures the product plus the exception flags the core raised during the operation. Presents the captured result on a valid/ready output stream, with a watchdog for a hung core.

Parameters:
FIFO_DEPTH, 4, operand-pair FIFO entries (power of two, >=2)
TIMEOUT_CYCLES, 32, max cycles in WAIT before the operation is aborted

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept a pair
in_a  in  32  operand A (IEEE-754 single)
in_b  in  32  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_product  out  32  captured product
out_flags  out  5  {timeout, underflow, overflow, infinit, nan}
mul_start_o  out  1  start pulse to core
mul_a_o  out  32  operand A to core
mul_b_o  out  32  operand B to core
mul_done_i  in  1  core done pulse
mul_product_i  in  32  core product
mul_nan_i, mul_inf_i, mul_ovf_i, mul_unf_i  in  1 each  core flags
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, any state including mid-operation):
  - FIFO emptied; state IDLE.
  - in_ready=1; out_valid=0; out_product=0; out_flags=0.
  - mul_start_o=0; mul_a_o=mul_b_o=0; busy_o=0.
  - Watchdog counter and flag accumulator cleared.
- FIFO:
  - Push on in_valid&&in_ready. in_ready = !full.
  - No same-cycle pass-through when full: a simultaneous pop does not raise in_ready in that cycle.
  - Occupancy counter is $clog2(FIFO_DEPTH)+1 bits; read/write pointers wrap modulo FIFO_DEPTH.
  - Push while empty is visible (not-empty) the next cycle.
- States: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: FIFO not empty -> ISSUE.
  - ISSUE (exactly 1 cycle):
    - Load mul_a_o/mul_b_o from FIFO head and pop.
    - mul_start_o=1 in this cycle only.
    - Clear accumulator and counter. -> WAIT.
  - WAIT:
    - mul_a_o/mul_b_o held stable.
    - Each cycle, accumulator |= {unf,ovf,inf,nan} inputs; counter increments.
    - mul_done_i=1: out_product<=mul_product_i; out_flags<={0, accumulator | current-cycle flags}; out_valid<=1 -> HOLD.
    - counter==TIMEOUT_CYCLES-1 without done: out_product<=32'h7FC00000; out_flags<={1, accumulator} -> HOLD.
    - Done and timeout in the same cycle: done wins, timeout bit=0.
  - HOLD:
    - out_valid=1; out_product/out_flags stable.
    - out_ready=1 -> out_valid<=0 -> IDLE.
    - Result is therefore one bubble before the next ISSUE.
- Latency (empty FIFO, idle core, out_ready=1):
  - Push edge E0; start high in cycle E1..E2.
  - out_valid rises the edge after done is sampled.
  - out_valid drops the edge after acceptance.
- Flags are sticky-ORed over the whole WAIT window, because core flags may pulse and drop before done. Flags before ISSUE are ignored.
- mul_done_i outside WAIT is ignored; it has no effect on state or outputs.
- mul_start_o is never asserted in WAIT or HOLD. At most one operation is outstanding.
- in_a/in_b are sampled only at push; later changes have no effect.

Decomposition:
- Package fp32_mul_pkg:
  - state enum seq_state_t.
  - flag index constants FLG_NAN=0, FLG_INF=1, FLG_OVF=2, FLG_UNF=3, FLG_TMO=4; FLAG_W=5.
  - FP32_QNAN=32'h7FC00000.
- Sub-module fp32_operand_fifo: 64-bit synchronous FIFO, parameter DEPTH, ports push/pop/full/empty/head.

Test Plan:
- Single op: push a=0x40000000, b=0x40400000; core model returns done with 0x40C00000 after 6 cycles -> one start pulse, out_valid with out_product=0x40C00000, out_flags=0, mul_a_o stable through WAIT.
- FIFO full: out_ready=0, push 1+FIFO_DEPTH pairs (the first moves to the core, the next 4 fill the FIFO) -> in_ready=0 on the 6th attempt. Release out_ready -> results emerge in push order, one start per result.
- Backpressure: hold out_ready=0 for 10 cycles after done -> out_valid stays 1, product and flags constant, no mul_start_o.
- Transient flag: core pulses mul_ovf_i for 2 cycles, drops it, then done with 0x7F7FFFFF -> out_flags=5'b00100.
- Timeout: core never asserts done -> exactly TIMEOUT_CYCLES after ISSUE, out_product=0x7FC00000, out_flags[4]=1. Spurious done afterwards in HOLD is ignored.
- Reset mid-WAIT with 2 queued pairs -> all outputs at reset values immediately; after release, no start until a new push.
